// File: rtl/sync_split_fifo.sv
// Purpose : synchronous FIFO storing wide words, read out as narrow slices (DATA_WIDTH -> OUT_DATA_WIDTH).
// Latency : a written word is visible on the read side the cycle after the write; slice reads are combinational.
// Backpressure: wr_ready_o low while full (writes dropped); rd_ready_o low while empty (reads ignored).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_i, wr_valid_i         wide write word and write request; wr_ready_o = space for one word
//   data_o, rd_valid_i         current narrow slice and consumer take; rd_ready_o = data_o valid
//   rd_last_o                  current slice is the final slice of its wide word
//   empty_o, full_o, counter   occupancy flags and stored word count (partially read head included)
//
// Build option: define SYNC_SPLIT_FIFO_MSB_FIRST_EN to emit slices most-significant first.
// Handshake and timing are the same in both orderings.
module sync_split_fifo #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int OUT_DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH     = 4,
    localparam int ADDR_WIDTH     = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      rd_last_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [ADDR_WIDTH:0]       counter
);

    localparam int CAT_NUM = DATA_WIDTH / OUT_DATA_WIDTH;
    localparam int SLC_W   = (CAT_NUM > 1) ? $clog2(CAT_NUM) : 1;
    localparam logic [SLC_W-1:0] SLC_LAST = SLC_W'(CAT_NUM - 1);

    // Pointer arithmetic and slice selection both rely on power-of-two sizes.
    if (CAT_NUM < 2 || (CAT_NUM & (CAT_NUM - 1)) != 0 ||
        CAT_NUM * OUT_DATA_WIDTH != DATA_WIDTH ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("sync_split_fifo: CAT_NUM and FIFO_DEPTH must be powers of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [SLC_W-1:0]    slc_cnt_q, slc_cnt_d;

    logic wr_hsk;
    logic rd_hsk;
    logic slc_last;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}});
    assign counter    = wr_ptr_q - rd_ptr_q;
    assign wr_ready_o = ~full_o;
    assign rd_ready_o = ~empty_o;

    // wr_ready_o comes from the registered state, so a write into a full
    // FIFO is refused even if the head word retires in the same cycle.
    assign wr_hsk    = wr_valid_i & wr_ready_o;
    assign rd_hsk    = rd_valid_i & rd_ready_o;
    assign slc_last  = (slc_cnt_q == SLC_LAST);
    assign rd_last_o = rd_ready_o & slc_last;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        slc_cnt_d = slc_cnt_q;
        if (wr_hsk) begin
            wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(1);
        end
        if (rd_hsk) begin
            // slc_cnt wraps to 0 naturally on the last slice (power-of-two CAT_NUM).
            slc_cnt_d = slc_cnt_q + SLC_W'(1);
            if (slc_last) begin
                rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            slc_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            slc_cnt_q <= slc_cnt_d;
        end
    end

    // Storage is not reset; contents only matter once the pointers say so.
    always_ff @(posedge clk) begin
        if (wr_hsk) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_i;
        end
    end

    logic [SLC_W-1:0]      slc_sel;
    logic [DATA_WIDTH-1:0] head_word;

`ifdef SYNC_SPLIT_FIFO_MSB_FIRST_EN
    assign slc_sel = SLC_LAST - slc_cnt_q;
`else
    assign slc_sel = slc_cnt_q;
`endif

    assign head_word = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        data_o = head_word[OUT_DATA_WIDTH-1:0];
        for (int i = 0; i < CAT_NUM; i++) begin
            if (slc_sel == SLC_W'(i)) begin
                data_o = head_word[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sync_split_fifo.sv
// Purpose : directed, table-driven check of sync_split_fifo at 32->8, depth 4.
// Latency : inputs are driven 1 time unit after a rising edge and outputs sampled on the falling edge.
// Backpressure: the bench exercises full/empty refusal through the vector table and hand sequences.
module tb_sync_split_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  data_o;
    logic        rd_valid_i;
    logic        rd_ready_o;
    logic        rd_last_o;
    logic        empty_o;
    logic        full_o;
    logic [2:0]  counter;

    int chk_cnt = 0;
    int err_cnt = 0;

    sync_split_fifo #(
        .DATA_WIDTH    (32),
        .OUT_DATA_WIDTH(8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data_i),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .data_o    (data_o),
        .rd_valid_i(rd_valid_i),
        .rd_ready_o(rd_ready_o),
        .rd_last_o (rd_last_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .counter   (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rv;
        logic        e_rdy;
        logic        e_last;
        logic        e_full;
        int          e_cnt;
        logic [31:0] e_word;
        int          e_k;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] exp_slc(input logic [31:0] w, input int k);
        int s;
`ifdef SYNC_SPLIT_FIFO_MSB_FIRST_EN
        s = 3 - k;
`else
        s = k;
`endif
        return w[8*s +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wv, input logic [31:0] wd, input logic rv,
                       input logic e_rdy, input logic e_last, input logic e_full,
                       input int e_cnt, input logic [31:0] e_word, input int e_k);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rv = rv;
        v.e_rdy = e_rdy; v.e_last = e_last; v.e_full = e_full;
        v.e_cnt = e_cnt; v.e_word = e_word; v.e_k = e_k;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic rv);
        wr_valid_i = wv;
        data_i     = wd;
        rd_valid_i = rv;
    endtask

    // Check every output of the current cycle; data only when a slice is valid.
    task automatic check_state(input string tag, input logic e_rdy, input logic e_last,
                               input logic e_full, input int e_cnt,
                               input logic [31:0] e_word, input int e_k);
        chk({tag, " rd_ready"}, 32'(rd_ready_o), 32'(e_rdy));
        chk({tag, " empty"},    32'(empty_o),    32'(!e_rdy));
        chk({tag, " full"},     32'(full_o),     32'(e_full));
        chk({tag, " wr_ready"}, 32'(wr_ready_o), 32'(!e_full));
        chk({tag, " rd_last"},  32'(rd_last_o),  32'(e_last));
        chk({tag, " counter"},  32'(counter),    32'(e_cnt));
        if (e_rdy) chk({tag, " data"}, 32'(data_o), 32'(exp_slc(e_word, e_k)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input logic wv, input logic [31:0] wd, input logic rv,
                         input logic e_rdy, input logic e_last, input logic e_full,
                         input int e_cnt, input logic [31:0] e_word, input int e_k);
        drive(wv, wd, rv);
        @(negedge clk);
        check_state(tag, e_rdy, e_last, e_full, e_cnt, e_word, e_k);
        tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_state("reset", 1'b0, 1'b0, 1'b0, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    localparam logic [31:0] WA = 32'hDDCCBBAA;
    localparam logic [31:0] W0 = 32'h13121110;
    localparam logic [31:0] W1 = 32'h23222120;
    localparam logic [31:0] W2 = 32'h33323130;
    localparam logic [31:0] W3 = 32'h43424140;
    localparam logic [31:0] W4 = 32'h53525150;
    localparam logic [31:0] W6 = 32'h63626160;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);

        //   wv    wd   rv    rdy   last  full cnt  word k
        // Basic word: write, then 4 back-to-back slices, then read on empty.
        add(1'b1, WA, 1'b0, 1'b0, 1'b0, 1'b0, 0, WA, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 2);
        add(1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1, WA, 3);
        add(1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 0, WA, 0);
        // Fill to full, then a 5th write that must be dropped.
        add(1'b1, W0, 1'b0, 1'b0, 1'b0, 1'b0, 0, W0, 0);
        add(1'b1, W1, 1'b0, 1'b1, 1'b0, 1'b0, 1, W0, 0);
        add(1'b1, W2, 1'b0, 1'b1, 1'b0, 1'b0, 2, W0, 0);
        add(1'b1, W3, 1'b0, 1'b1, 1'b0, 1'b0, 3, W0, 0);
        add(1'b1, W4, 1'b0, 1'b1, 1'b0, 1'b1, 4, W0, 0);
        // Drain W0 while full; the retiring slice write attempt is still refused.
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 4, W0, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 4, W0, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 4, W0, 2);
        add(1'b1, W4, 1'b1, 1'b1, 1'b1, 1'b1, 4, W0, 3);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 3, W1, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 3, W1, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 3, W1, 2);
        add(1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 3, W1, 3);
        // counter=2: accepted write together with last-slice read keeps counter at 2.
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W2, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W2, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W2, 2);
        add(1'b1, W6, 1'b1, 1'b1, 1'b1, 1'b0, 2, W2, 3);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W3, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W3, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, W3, 2);
        add(1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 2, W3, 3);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, W6, 0);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, W6, 1);
        add(1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, W6, 2);
        add(1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1, W6, 3);
        add(1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 0, W6, 0);

        repeat (2) @(posedge clk);
        do_reset();

        foreach (vecs[i]) begin
            cycle($sformatf("vec%0d", i), vecs[i].wv, vecs[i].wd, vecs[i].rv,
                  vecs[i].e_rdy, vecs[i].e_last, vecs[i].e_full,
                  vecs[i].e_cnt, vecs[i].e_word, vecs[i].e_k);
        end

        // Hold: two slices read, rd_valid_i low for 3 cycles, then resume.
        do_reset();
        cycle("hold_wr", 1'b1, WA, 1'b0, 1'b0, 1'b0, 1'b0, 0, WA, 0);
        cycle("hold_r0", 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 0);
        cycle("hold_r1", 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 1);
        for (int j = 0; j < 3; j++) begin
            cycle($sformatf("hold_idle%0d", j), 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1, WA, 2);
        end
        cycle("hold_r2", 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 2);
        cycle("hold_r3", 1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1, WA, 3);
        cycle("hold_end", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, WA, 0);

        // Asynchronous reset in the middle of a word (slc_cnt = 2).
        cycle("ar_wr", 1'b1, WA, 1'b0, 1'b0, 1'b0, 1'b0, 0, WA, 0);
        cycle("ar_wr2", 1'b1, W1, 1'b1, 1'b1, 1'b0, 1'b0, 1, WA, 0);
        cycle("ar_r1", 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 2, WA, 1);
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_state("ar_pre", 1'b1, 1'b0, 1'b0, 2, WA, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("ar_async", 1'b0, 1'b0, 1'b0, 0, WA, 0);
        @(posedge clk);
        #1;
        check_state("ar_held", 1'b0, 1'b0, 1'b0, 0, WA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cycle("ar_new_wr", 1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h44332211, 0);
        cycle("ar_new_r0", 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h44332211, 0);
        cycle("ar_new_r1", 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h44332211, 1);
        cycle("ar_new_r2", 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h44332211, 2);
        cycle("ar_new_r3", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'h44332211, 3);
        cycle("ar_new_end", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
